stopwatch_uart_reporter: RTL and testbench

Serial transmitter that reports the stopwatch count over the USB-UART link, the transmit-side counterpart of the board's `usb_rx`/`usb_tx` serial interface. On a `send` request it snapshots the `number` bus driven by `CounterModule`, converts each 4-bit digit to one ASCII character, and shifts the characters out on `usb_tx` as 8N1 frames. It sits in `au_top` beside `Display_Digits` and drives `usb_tx` in place of the rx-to-tx loopback.

---
 rtl/stopwatch_uart_reporter.sv | 172 +++++++++++++++++
 tb/tb_stopwatch_uart_reporter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_uart_reporter.sv
// Serial stopwatch reporter: snapshots the digit bus on request and sends one ASCII char per digit as 8N1 frames.
// Optional CR/LF suffix per report is compiled in with `define STOPWATCH_UART_CRLF_EN.
module stopwatch_uart_reporter #(
  parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int BAUD_RATE                   = 1_000_000,
  parameter int NUMBER_OF_DIGITS            = 4,
  parameter int NUMBER_OF_BITS_PER_DIGIT    = 4
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] number,
  input  logic                                                 send,
  output logic                                                 busy,
  output logic                                                 usb_tx
);

  localparam int CLKS_PER_BIT = BOARD_CLOCK_FREQUENCY_IN_HZ / BAUD_RATE;
  localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int NUM_W        = NUMBER_OF_DIGITS * NUMBER_OF_BITS_PER_DIGIT;
`ifdef STOPWATCH_UART_CRLF_EN
  localparam int CHARS        = NUMBER_OF_DIGITS + 2;
`else
  localparam int CHARS        = NUMBER_OF_DIGITS;
`endif
  localparam int CHAR_W       = (CHARS > 1) ? $clog2(CHARS) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CHAR_W-1:0] CHAR_LAST = CHAR_W'(CHARS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BAUD_W-1:0]   r_baud_cnt;
  logic [BAUD_W-1:0]   w_baud_cnt_nxt;
  logic [2:0]          r_bit_idx;
  logic [2:0]          w_bit_idx_nxt;
  logic [CHAR_W-1:0]   r_char_idx;
  logic [CHAR_W-1:0]   w_char_idx_nxt;
  logic [NUM_W-1:0]    r_snapshot;
  logic                r_tx;
  logic                r_busy;
  logic                w_tx_nxt;
  logic                w_busy_nxt;
  logic                w_accept;
  logic                w_baud_done;
  logic [7:0]          w_char;

  function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
    if (d < 4'd10) begin
      return 8'h30 + {4'd0, d};
    end
    return 8'h37 + {4'd0, d};
  endfunction

  // Character idx of the report: digits MSB first, then the optional suffix.
  function automatic logic [7:0] char_at(input logic [NUM_W-1:0]  snap,
                                         input logic [CHAR_W-1:0] idx);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
      if (idx == CHAR_W'(i)) begin
        c = digit_to_ascii(4'(snap[(NUMBER_OF_DIGITS-1-i)*NUMBER_OF_BITS_PER_DIGIT +: NUMBER_OF_BITS_PER_DIGIT]));
      end
    end
`ifdef STOPWATCH_UART_CRLF_EN
    if (idx == CHAR_W'(NUMBER_OF_DIGITS)) begin
      c = 8'h0D;
    end
    if (idx == CHAR_W'(NUMBER_OF_DIGITS + 1)) begin
      c = 8'h0A;
    end
`endif
    return c;
  endfunction

  assign w_baud_done = (r_baud_cnt == BAUD_LAST);
  assign w_char      = char_at(r_snapshot, r_char_idx);

  always_comb begin
    w_state_nxt    = r_state;
    w_baud_cnt_nxt = w_baud_done ? '0 : r_baud_cnt + 1'b1;
    w_bit_idx_nxt  = r_bit_idx;
    w_char_idx_nxt = r_char_idx;
    w_accept       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_cnt_nxt = '0;
        if (send) begin
          w_accept       = 1'b1;
          w_state_nxt    = S_START;
          w_char_idx_nxt = '0;
          w_bit_idx_nxt  = '0;
        end
      end
      S_START: begin
        if (w_baud_done) begin
          w_state_nxt   = S_DATA;
          w_bit_idx_nxt = '0;
        end
      end
      S_DATA: begin
        if (w_baud_done) begin
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (w_baud_done) begin
          if (r_char_idx == CHAR_LAST) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_char_idx_nxt = r_char_idx + 1'b1;
            w_state_nxt    = S_START;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_IDLE:  w_tx_nxt = 1'b1;
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_char[w_bit_idx_nxt];
      S_STOP:  w_tx_nxt = 1'b1;
      default: w_tx_nxt = 1'b1;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_char_idx <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_char_idx <= w_char_idx_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_snapshot <= number;
    end
  end

  assign usb_tx = r_tx;
  assign busy   = r_busy;

endmodule

// File: tb/tb_stopwatch_uart_reporter.sv
// Bench for stopwatch_uart_reporter: a queue-based report model feeds a UART decoder monitor and a busy-width monitor.
module tb_stopwatch_uart_reporter;

  localparam int CPB = 100;
  localparam int ND  = 4;
`ifdef STOPWATCH_UART_CRLF_EN
  localparam int CHARS = ND + 2;
`else
  localparam int CHARS = ND;
`endif
  localparam int T = CHARS * 10 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        send = 1'b0;
  logic [15:0] number = 16'h0000;
  logic        busy;
  logic        usb_tx;

  always #5 clk = ~clk;

  stopwatch_uart_reporter dut (
    .clk    (clk),
    .rst    (rst),
    .number (number),
    .send   (send),
    .busy   (busy),
    .usb_tx (usb_tx)
  );

  int   errors = 0;
  int   checks = 0;
  logic [7:0] exp_q[$];
  int   edge_idx = 0;
  int   free_at = 0;
  int   exp_reports = 0;
  int   act_reports = 0;
  bit   dec_abort = 1'b0;
  bit   busy_abort = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] asc(input int d);
    if (d < 10) return 8'(48 + d);
    return 8'(65 + d - 10);
  endfunction

  task automatic push_report(input logic [15:0] n);
    for (int i = ND - 1; i >= 0; i--) begin
      exp_q.push_back(asc(int'(n >> (4 * i)) & 15));
    end
`ifdef STOPWATCH_UART_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
    exp_reports++;
  endtask

  // One clock: drive inputs, let the edge happen, update the model's view of acceptance.
  task automatic step(input logic s, input logic [15:0] n, input logic r);
    @(negedge clk);
    send   = s;
    number = n;
    rst    = r;
    @(posedge clk);
    edge_idx++;
    if (r) begin
      if (edge_idx < free_at) begin
        busy_abort = 1'b1;
        dec_abort  = 1'b1;
      end
      exp_q.delete();
      free_at = edge_idx + 1;
    end else if (s && edge_idx >= free_at) begin
      push_report(n);
      free_at = edge_idx + T + 1;
    end
    #1;
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (busy === 1'b1 && k < bound) begin
      step(1'b0, number, 1'b0);
      k++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  initial begin : decoder
    logic [7:0] b;
    logic       stopb;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (usb_tx === 1'b0) begin
        dec_abort = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = usb_tx;
        end
        repeat (CPB) @(negedge clk);
        stopb = usb_tx;
        if (!dec_abort) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_char: got %0h expected no character (t=%0t)", b, $time);
          end else begin
            e = exp_q.pop_front();
            chk("char", b, e);
            chk("stop_bit", stopb, 1);
          end
        end
      end
    end
  end

  initial begin : busy_mon
    int   w;
    logic prev;
    w = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        if (!prev) act_reports++;
        w++;
      end else if (prev) begin
        if (!busy_abort) chk("busy_width", w, T);
        busy_abort = 1'b0;
        w = 0;
      end
      prev = (busy === 1'b1);
    end
  end

  initial begin : stim
    int w;
    int k;
    int g;
    int gap;

    repeat (3) begin
      step(1'b0, 16'h0000, 1'b1);
      chk("reset_tx", usb_tx, 1);
      chk("reset_busy", busy, 0);
    end
    repeat (5) begin
      step(1'b0, 16'h0000, 1'b0);
      chk("idle_tx", usb_tx, 1);
    end

    // Basic report with latency and bit-width measurement
    chk("pre_send_tx", usb_tx, 1);
    step(1'b1, 16'h1234, 1'b0);
    chk("start_latency_tx", usb_tx, 0);
    chk("start_latency_busy", busy, 1);
    w = 0;
    do begin
      w++;
      step(1'b0, 16'h1234, 1'b0);
    end while (usb_tx === 1'b0 && w < 1000);
    chk("start_bit_width", w, CPB);
    w = 0;
    do begin
      w++;
      step(1'b0, 16'h1234, 1'b0);
    end while (usb_tx === 1'b1 && w < 1000);
    chk("data_bit_width", w, CPB);
    wait_idle(T + 100);
    repeat (20) step(1'b0, 16'h1234, 1'b0);

    // Hex digits
    step(1'b1, 16'h09AF, 1'b0);
    wait_idle(T + 100);
    repeat (20) step(1'b0, 16'h09AF, 1'b0);

    // Snapshot and ignored request
    step(1'b1, 16'h0001, 1'b0);
    repeat (499) step(1'b0, 16'h0001, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0);
    wait_idle(T + 100);
    repeat (200) step(1'b0, 16'hFFFF, 1'b0);

    // Back-to-back reports with send held
    step(1'b1, 16'h0042, 1'b0);
    k = 0;
    while (busy === 1'b1 && k < T + 10) begin
      step(1'b1, 16'h0042, 1'b0);
      k++;
    end
    chk("b2b_gap_tx", usb_tx, 1);
    g = 0;
    while (busy !== 1'b1 && g < 10) begin
      g++;
      step(1'b1, 16'h0042, 1'b0);
    end
    chk("b2b_gap", g, 1);
    chk("b2b_restart_tx", usb_tx, 0);
    wait_idle(T + 100);
    repeat (20) step(1'b0, 16'h0042, 1'b0);

    // Reset during the data bits of the second character
    step(1'b1, 16'h1234, 1'b0);
    repeat (1400) step(1'b0, 16'h1234, 1'b0);
    step(1'b0, 16'h1234, 1'b1);
    chk("midreset_tx", usb_tx, 1);
    chk("midreset_busy", busy, 0);
    repeat (1500) step(1'b0, 16'h1234, 1'b0);
    chk("post_reset_idle_tx", usb_tx, 1);
    step(1'b1, 16'h5678, 1'b0);
    wait_idle(T + 100);
    repeat (20) step(1'b0, 16'h5678, 1'b0);

    // Randomized requests and number changes
    for (int it = 0; it < 6; it++) begin
      step(1'b1, 16'($urandom), 1'b0);
      gap = $urandom_range(500, 3500);
      repeat (gap) step(($urandom_range(0, 199) == 0), 16'($urandom), 1'b0);
    end

    wait_idle(2 * T);
    repeat (100) step(1'b0, number, 1'b0);
    chk("queue_drained", exp_q.size(), 0);
    chk("report_count", act_reports, exp_reports);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
